modn_cascade_tracker: RTL and testbench
=======================================

// Module: modn_cascade_tracker
// PURPOSE
//  Downstream consumer of the up/down mod-N counter's count bus.
//  - Samples count every clock and classifies each change as step-up, step-down, up-wrap, down-wrap or illegal jump.
//  - Maintains a cascaded second digit ("tens") so two mod-N stages form a 2-digit up/down counter.
//  - Flags illegal transitions for the bench and for system monitors.
// PARAMETERS
//  N    10  modulus of upstream counter and of tens digit; legal range 3..2**MSB
//  MSB   4  width of count_in and tens
// PORTS
//  clk       in   1      rising-edge clock, same domain as upstream counter
//  arst      in   1      asynchronous reset, active-high
//  count_in  in   MSB    upstream counter value
//  tens      out  MSB    cascaded digit, 0..N-1
//  dir_up    out  1      direction of last legal step/wrap; 1 = up
//  step      out  1      1-cycle pulse on any legal change (step or wrap)
//  wrap_up   out  1      1-cycle pulse: count_in went N-1 -> 0
//  wrap_dn   out  1      1-cycle pulse: count_in went 0 -> N-1
//  tens_wrap out  1      1-cycle pulse: tens wrapped, either direction
//  err       out  1      1-cycle pulse: illegal transition or out-of-range value
//  err_stky  out  1      sticky error; cleared only by arst
// BEHAVIOUR
//  - Reset values (async, immediate): tens=0, dir_up=1, all pulses 0, err_stky=0.
//    Internal prev_q=0, prev_vld=0.
//  - Every edge: prev_q<=count_in, prev_vld<=1.
//  - First edge after reset release (prev_vld=0): prime prev_q only; no pulses, tens unchanged.
//  - With prev_vld=1, classify count_in (c) against prev_q (p); first match wins:
//    1. c>=N: err, err_stky<=1; tens and dir_up unchanged.
//    2. c==p: hold; no pulses.
//    3. p<N-1 && c==p+1: step, dir_up<=1.
//    4. p==N-1 && c==0: step, wrap_up, dir_up<=1.
//       tens<=tens+1 (N-1 -> 0 wraps and pulses tens_wrap).
//    5. p>0 && c==p-1: step, dir_up<=0.
//    6. p==0 && c==N-1: step, wrap_dn, dir_up<=0.
//       tens<=tens-1 (0 -> N-1 wraps and pulses tens_wrap).
//    7. Otherwise: err, err_stky<=1; tens, dir_up unchanged.
//  - Priority makes rules 3/4 (up) win over 5/6 (down) on any ambiguity.
//  - All outputs registered. Latency: count_in changes after edge k; pulses are high for exactly the cycle after edge k+1.
//  - Pulses are never held: consecutive legal changes give back-to-back 1-cycle pulses.
//  - tens arithmetic is mod N on MSB bits; never leaves 0..N-1.
//  - Reset asserted mid-operation: all state clears immediately; the next sample after release re-primes (rule "first edge").
// CONFIGURATION
//  SEG7_OUT_EN defined:
//   - Adds outputs seg_ones[6:0] and seg_tens[6:0], active-high gfedcba.
//   - seg_ones decodes prev_q; seg_tens decodes tens.
//   - Both are registered one cycle behind their source.
//   - Digits 0-9 use standard glyphs; values 10..15 show blank (7'b0); reset value 7'b0.
//  SEG7_OUT_EN undefined: no seg ports, no decode logic; all other behaviour identical.
// TESTING (N=10, MSB=4)
//  1. arst=1 15ns, release, count_in held 0 -> tens=0, dir_up=1, no pulses, err_stky=0.
//  2. count_in 0,1..9,0 one per cycle -> 10 step pulses; wrap_up once on 9->0; tens 0->1; dir_up=1.
//  3. From tens=0, count_in 2,1,0,9 -> wrap_dn on 0->9, tens=9, tens_wrap pulse, dir_up=0.
//  4. count_in 3 -> 7, then 12 -> err pulse each time, err_stky=1, tens unchanged.
//     Following legal 12 -> ... re-evaluated against prev_q=12 (err).
//  5. Twenty up-wraps with tens 9 -> tens returns 0 with a tens_wrap pulse.
//     arst pulsed mid-run -> tens=0 at once and no pulse on the first sample after release.
//  6. With SEG7_OUT_EN: count_in=7 after tens=4 -> seg_ones=7'b0000111, seg_tens=7'b1100110.

Source files
------------

// File: rtl/modn_cascade_tracker.sv
// modn_cascade_tracker
//   Watches the count bus of an upstream up/down mod-N counter. Each clock
//   the new value is classified against the previous sample as a step up,
//   step down, up-wrap, down-wrap or illegal jump. Wraps advance a cascaded
//   "tens" digit, so the upstream stage and this digit behave as one
//   two-digit up/down counter.
//
//   Optional feature macro: SEG7_OUT_EN
//     Defined   -> adds seg_ones/seg_tens 7-segment outputs (active-high,
//                  gfedcba), registered one cycle behind prev_q / tens.
//     Undefined -> no segment ports and no decode logic.
//
//   There is no handshake on this block: count_in is sampled on every
//   rising edge of clk, and every output is a registered value that is
//   valid in the cycle after the edge that sampled the change.
//   All pulse outputs are high for exactly one cycle.
module modn_cascade_tracker #(
  parameter int N   = 10,
  parameter int MSB = 4
) (
  input  logic           clk,
  input  logic           arst,
  input  logic [MSB-1:0] count_in,
  output logic [MSB-1:0] tens,
  output logic           dir_up,
  output logic           step,
  output logic           wrap_up,
  output logic           wrap_dn,
  output logic           tens_wrap,
  output logic           err,
  output logic           err_stky
`ifdef SEG7_OUT_EN
  ,
  output logic [6:0]     seg_ones,
  output logic [6:0]     seg_tens
`endif
);

  // Modulus widened by one bit so that N == 2**MSB still compares correctly.
  localparam logic [MSB:0]   N_EXT = N[MSB:0];
  localparam int             NM1   = N - 1;
  localparam logic [MSB-1:0] MAXV  = NM1[MSB-1:0];
  localparam logic [MSB-1:0] ONE   = {{(MSB-1){1'b0}}, 1'b1};
  localparam logic [MSB-1:0] ZERO  = '0;

  // Previous sample and whether it has been primed since reset.
  logic [MSB-1:0] prev_q;
  logic           prev_vld;

  // Transition classification of count_in against prev_q.
  logic out_of_range;
  logic is_hold;
  logic up_step;
  logic up_wrap;
  logic dn_step;
  logic dn_wrap;

  // Next-state values for the registered outputs.
  logic [MSB-1:0] tens_nxt;
  logic           dir_up_nxt;
  logic           step_nxt;
  logic           wrap_up_nxt;
  logic           wrap_dn_nxt;
  logic           tens_wrap_nxt;
  logic           err_nxt;
  logic           err_stky_nxt;

  // Classify the current sample; the first-match priority is applied below.
  always_comb begin
    out_of_range = ({1'b0, count_in} >= N_EXT);
    is_hold      = (count_in == prev_q);
    up_step      = (prev_q < MAXV) && (count_in == prev_q + ONE);
    up_wrap      = (prev_q == MAXV) && (count_in == ZERO);
    dn_step      = (prev_q != ZERO) && (count_in == prev_q - ONE);
    dn_wrap      = (prev_q == ZERO) && (count_in == MAXV);
  end

  // Decide next outputs; up rules sit above down rules so up wins any tie.
  always_comb begin
    tens_nxt      = tens;
    dir_up_nxt    = dir_up;
    step_nxt      = 1'b0;
    wrap_up_nxt   = 1'b0;
    wrap_dn_nxt   = 1'b0;
    tens_wrap_nxt = 1'b0;
    err_nxt       = 1'b0;
    err_stky_nxt  = err_stky;
    if (prev_vld) begin
      if (out_of_range) begin
        err_nxt      = 1'b1;
        err_stky_nxt = 1'b1;
      end else if (is_hold) begin
        step_nxt = 1'b0;
      end else if (up_step) begin
        step_nxt   = 1'b1;
        dir_up_nxt = 1'b1;
      end else if (up_wrap) begin
        step_nxt    = 1'b1;
        wrap_up_nxt = 1'b1;
        dir_up_nxt  = 1'b1;
        if (tens == MAXV) begin
          tens_nxt      = ZERO;
          tens_wrap_nxt = 1'b1;
        end else begin
          tens_nxt = tens + ONE;
        end
      end else if (dn_step) begin
        step_nxt   = 1'b1;
        dir_up_nxt = 1'b0;
      end else if (dn_wrap) begin
        step_nxt    = 1'b1;
        wrap_dn_nxt = 1'b1;
        dir_up_nxt  = 1'b0;
        if (tens == ZERO) begin
          tens_nxt      = MAXV;
          tens_wrap_nxt = 1'b1;
        end else begin
          tens_nxt = tens - ONE;
        end
      end else begin
        err_nxt      = 1'b1;
        err_stky_nxt = 1'b1;
      end
    end
  end

  // Sample history: always track count_in, mark primed after first edge.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      prev_q   <= '0;
      prev_vld <= 1'b0;
    end else begin
      prev_q   <= count_in;
      prev_vld <= 1'b1;
    end
  end

  // Register all tracker outputs.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      tens      <= '0;
      dir_up    <= 1'b1;
      step      <= 1'b0;
      wrap_up   <= 1'b0;
      wrap_dn   <= 1'b0;
      tens_wrap <= 1'b0;
      err       <= 1'b0;
      err_stky  <= 1'b0;
    end else begin
      tens      <= tens_nxt;
      dir_up    <= dir_up_nxt;
      step      <= step_nxt;
      wrap_up   <= wrap_up_nxt;
      wrap_dn   <= wrap_dn_nxt;
      tens_wrap <= tens_wrap_nxt;
      err       <= err_nxt;
      err_stky  <= err_stky_nxt;
    end
  end

`ifdef SEG7_OUT_EN
  // Active-high gfedcba glyphs for 0-9; anything else is blank.
  function automatic logic [6:0] seg_decode(input logic [MSB-1:0] v);
    logic [6:0] g;
    case (v)
      0:       g = 7'b0111111;
      1:       g = 7'b0000110;
      2:       g = 7'b1011011;
      3:       g = 7'b1001111;
      4:       g = 7'b1100110;
      5:       g = 7'b1101101;
      6:       g = 7'b1111101;
      7:       g = 7'b0000111;
      8:       g = 7'b1111111;
      9:       g = 7'b1101111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // Segment outputs trail their source registers by one cycle.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      seg_ones <= 7'b0;
      seg_tens <= 7'b0;
    end else begin
      seg_ones <= seg_decode(prev_q);
      seg_tens <= seg_decode(tens);
    end
  end
`endif

endmodule

// File: tb/tb_modn_cascade_tracker.sv
// Directed bench for modn_cascade_tracker (N=10, MSB=4).
// Output vector layout: {tens[3:0], dir_up, step, wrap_up, wrap_dn,
// tens_wrap, err, err_stky}.
module tb_modn_cascade_tracker;

  logic       clk;
  logic       arst;
  logic [3:0] count_in;
  logic [3:0] tens;
  logic       dir_up;
  logic       step;
  logic       wrap_up;
  logic       wrap_dn;
  logic       tens_wrap;
  logic       err;
  logic       err_stky;
`ifdef SEG7_OUT_EN
  logic [6:0] seg_ones;
  logic [6:0] seg_tens;
`endif

  int tests = 0;
  int fails = 0;
  logic [10:0] exp_q[$];
  logic [10:0] obs;

  assign obs = {tens, dir_up, step, wrap_up, wrap_dn, tens_wrap, err, err_stky};

  modn_cascade_tracker #(.N(10), .MSB(4)) dut (
    .clk       (clk),
    .arst      (arst),
    .count_in  (count_in),
    .tens      (tens),
    .dir_up    (dir_up),
    .step      (step),
    .wrap_up   (wrap_up),
    .wrap_dn   (wrap_dn),
    .tens_wrap (tens_wrap),
    .err       (err),
    .err_stky  (err_stky)
`ifdef SEG7_OUT_EN
    ,
    .seg_ones  (seg_ones),
    .seg_tens  (seg_tens)
`endif
  );

  // Clock / reset: first rising edge at 7 ns, period 10 ns.
  initial begin
    clk = 1'b0;
    #2;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] ev(input int t, input bit d, input bit s,
                                     input bit wu, input bit wd, input bit tw,
                                     input bit e, input bit st);
    return {t[3:0], d, s, wu, wd, tw, e, st};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [10:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  // Drive one sample, let one edge sample it, compare against the queued value.
  task automatic drive(input logic [3:0] v, input string tag, input logic [10:0] exp);
    count_in = v;
    exp_q.push_back(exp);
    tick();
    check(tag, exp_q.pop_front());
  endtask

  task automatic set_count(input logic [3:0] v);
    count_in = v;
    tick();
  endtask

  int t;

  initial begin
    // 1. reset
    arst     = 1'b1;
    count_in = 4'd0;
    #5;
    check("reset_hold", ev(0, 1, 0, 0, 0, 0, 0, 0));
    #10;
    arst = 1'b0;
    #1;
    check("reset_release", ev(0, 1, 0, 0, 0, 0, 0, 0));
    drive(4'd0, "prime", ev(0, 1, 0, 0, 0, 0, 0, 0));
    drive(4'd0, "hold",  ev(0, 1, 0, 0, 0, 0, 0, 0));

    // 2. count up 1..9 then wrap to 0
    for (int v = 1; v <= 9; v++)
      drive(v[3:0], "up_step", ev(0, 1, 1, 0, 0, 0, 0, 0));
    drive(4'd0, "up_wrap",         ev(1, 1, 1, 1, 0, 0, 0, 0));
    drive(4'd0, "hold_after_wrap", ev(1, 1, 0, 0, 0, 0, 0, 0));

    // 3. async reset mid-cycle, then count down through a down-wrap
    #3;
    arst     = 1'b1;
    count_in = 4'd2;
    #1;
    check("arst_async", ev(0, 1, 0, 0, 0, 0, 0, 0));
    #2;
    arst = 1'b0;
    drive(4'd2, "reprime",  ev(0, 1, 0, 0, 0, 0, 0, 0));
    drive(4'd1, "dn_step",  ev(0, 0, 1, 0, 0, 0, 0, 0));
    drive(4'd0, "dn_step0", ev(0, 0, 1, 0, 0, 0, 0, 0));
    drive(4'd9, "dn_wrap",  ev(9, 0, 1, 0, 1, 1, 0, 0));

    // 4. illegal jumps and out-of-range values
    drive(4'd3,  "jump_9_3",        ev(9, 0, 0, 0, 0, 0, 1, 1));
    drive(4'd7,  "jump_3_7",        ev(9, 0, 0, 0, 0, 0, 1, 1));
    drive(4'd12, "out_of_range",    ev(9, 0, 0, 0, 0, 0, 1, 1));
    drive(4'd3,  "after_oor",       ev(9, 0, 0, 0, 0, 0, 1, 1));
    drive(4'd4,  "legal_after_err", ev(9, 1, 1, 0, 0, 0, 0, 1));
    drive(4'd4,  "hold_sticky",     ev(9, 1, 0, 0, 0, 0, 0, 1));

    // 5. twenty up-wraps starting from tens=9
    for (int v = 5; v <= 9; v++)
      drive(v[3:0], "climb", ev(9, 1, 1, 0, 0, 0, 0, 1));
    t = 9;
    for (int w = 0; w < 20; w++) begin
      t = (t + 1) % 10;
      drive(4'd0, "wrap_n", ev(t, 1, 1, 1, 0, (t == 0), 0, 1));
      if (w < 19)
        for (int v = 1; v <= 9; v++)
          drive(v[3:0], "step_n", ev(t, 1, 1, 0, 0, 0, 0, 1));
    end
    drive(4'd1, "step_final", ev(9, 1, 1, 0, 0, 0, 0, 1));

    // reset while a step pulse is high
    #3;
    arst = 1'b1;
    #1;
    check("arst_midrun", ev(0, 1, 0, 0, 0, 0, 0, 0));
    #2;
    arst = 1'b0;
    drive(4'd5, "reprime2",       ev(0, 1, 0, 0, 0, 0, 0, 0));
    drive(4'd6, "step_after_rst", ev(0, 1, 1, 0, 0, 0, 0, 0));

`ifdef SEG7_OUT_EN
    // 6. bring tens to 4 and count to 7, then check glyphs
    for (int r = 0; r < 4; r++) begin
      for (int v = 7; v <= 9; v++) set_count(v[3:0]);
      set_count(4'd0);
      if (r < 3)
        for (int v = 1; v <= 6; v++) set_count(v[3:0]);
    end
    for (int v = 1; v <= 7; v++) set_count(v[3:0]);
    tick();
    tests++;
    assert ({seg_ones, seg_tens} === {7'b0000111, 7'b1100110}) else begin
      fails++;
      $error("FAIL seg7: observed %b_%b expected 0000111_1100110", seg_ones, seg_tens);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
